// File: rtl/reset_seq_gen.sv
// Sequenced reset generator: holds all downstream domains in reset, then
// releases them one at a time in ascending order, with a DFT bypass and a SW request/ack handshake.
module reset_seq_gen #(
   parameter int NUM_DOM  = 4,
   parameter int HOLD_CYC = 16,
   parameter int GAP_CYC  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sw_reset_req,
   input  logic               test_mode,
   input  logic               direct_reset_,
   output logic [NUM_DOM-1:0] outreset_,
   output logic               busy,
   output logic               sw_reset_ack
);

   localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam int IW      = $clog2(NUM_DOM + 1);

   typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;

   state_t               state_q, state_n;
   logic [CW-1:0]        cnt_q, cnt_n;
   logic [IW-1:0]        idx_q, idx_n;
   logic                 pend_q, pend_n;
   logic [NUM_DOM-1:0]   rel_q, rel_n;
   logic                 ack_q, ack_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HOLD;
         cnt_q   <= '0;
         idx_q   <= '0;
         pend_q  <= 1'b0;
         rel_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         idx_q   <= idx_n;
         pend_q  <= pend_n;
         rel_q   <= rel_n;
         ack_q   <= ack_n;
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      idx_n   = idx_q;
      pend_n  = pend_q;
      rel_n   = rel_q;
      ack_n   = 1'b0;
      if (sw_reset_req) begin
         // A request in any state (re)starts the sequence; held high it pins cnt at 0
         state_n = HOLD;
         cnt_n   = '0;
         idx_n   = '0;
         pend_n  = 1'b1;
         rel_n   = '0;
      end else begin
         case (state_q)
            HOLD: begin
               if (cnt_q == CW'(HOLD_CYC - 1)) begin
                  rel_n[0] = 1'b1;
                  cnt_n    = '0;
                  if (NUM_DOM == 1) begin
                     state_n = IDLE;
                     ack_n   = pend_q;
                     pend_n  = 1'b0;
                  end else begin
                     state_n = RELEASE;
                     idx_n   = IW'(1);
                  end
               end else begin
                  cnt_n = cnt_q + CW'(1);
               end
            end
            RELEASE: begin
               if (cnt_q == CW'(GAP_CYC - 1)) begin
                  for (int unsigned k = 0; k < NUM_DOM; k++) begin
                     if (IW'(k) == idx_q) rel_n[k] = 1'b1;
                  end
                  idx_n = idx_q + IW'(1);
                  cnt_n = '0;
                  if (idx_q == IW'(NUM_DOM - 1)) begin
                     state_n = IDLE;
                     ack_n   = pend_q;
                     pend_n  = 1'b0;
                  end
               end else begin
                  cnt_n = cnt_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign outreset_    = test_mode ? {NUM_DOM{direct_reset_}} : rel_q;
   assign busy         = (state_q != IDLE);
   assign sw_reset_ack = ack_q;

endmodule

// File: tb/tb_reset_seq_gen.sv
// Scoreboard bench for reset_seq_gen: default instance plus a 1/1/1 corner instance,
// checked against an elapsed-time reference model.
module tb_reset_seq_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sw_reset_req = 1'b0;
   logic       test_mode = 1'b0;
   logic       direct_reset_ = 1'b0;
   logic [3:0] outreset_;
   logic       busy, sw_reset_ack;
   logic [0:0] outreset1_;
   logic       busy1, sw_reset_ack1;

   always #5 clk = ~clk;

   reset_seq_gen #(.NUM_DOM(4), .HOLD_CYC(16), .GAP_CYC(4)) u_dut (
      .clk(clk), .rst(rst), .sw_reset_req(sw_reset_req), .test_mode(test_mode),
      .direct_reset_(direct_reset_), .outreset_(outreset_), .busy(busy),
      .sw_reset_ack(sw_reset_ack));

   reset_seq_gen #(.NUM_DOM(1), .HOLD_CYC(1), .GAP_CYC(1)) u_dut1 (
      .clk(clk), .rst(rst), .sw_reset_req(sw_reset_req), .test_mode(test_mode),
      .direct_reset_(direct_reset_), .outreset_(outreset1_), .busy(busy1),
      .sw_reset_ack(sw_reset_ack1));

   // Model: e = edges since the sequence (re)started; domain k is out of reset once
   // e >= HOLD + k*GAP, and the sequence is done at e == HOLD + (N-1)*GAP.
   typedef struct {
      int e;
      bit pend;
      bit ack;
   } model_t;

   typedef struct {
      logic [3:0] o;
      logic       b;
      logic       a;
      logic       o1;
      logic       b1;
      logic       a1;
   } exp_t;

   exp_t   sb[$];
   model_t m4 = '{e: 0, pend: 1'b0, ack: 1'b0};
   model_t m1 = '{e: 0, pend: 1'b0, ack: 1'b0};
   int     n_vec = 0;
   int     n_bad = 0;

   function automatic model_t step(model_t m, bit r, bit s, int last);
      model_t n = m;
      n.ack = 1'b0;
      if (r) begin
         n.e = 0;
         n.pend = 1'b0;
      end else if (s) begin
         n.e = 0;
         n.pend = 1'b1;
      end else if (m.e < last) begin
         n.e = m.e + 1;
         if (n.e == last) begin
            n.ack  = m.pend;
            n.pend = 1'b0;
         end
      end
      return n;
   endfunction

   function automatic logic [3:0] rel_bits(int e, int hold, int gap, int n);
      logic [3:0] v = '0;
      for (int k = 0; k < n; k++) v[k] = (e >= hold + k * gap);
      return v;
   endfunction

   always @(posedge clk) begin
      exp_t x;
      m4 = step(m4, rst, sw_reset_req, 16 + 3 * 4);
      m1 = step(m1, rst, sw_reset_req, 1);
      x.o  = test_mode ? {4{direct_reset_}} : rel_bits(m4.e, 16, 4, 4);
      x.b  = (m4.e < 28);
      x.a  = m4.ack;
      x.o1 = test_mode ? direct_reset_ : (m1.e >= 1);
      x.b1 = (m1.e < 1);
      x.a1 = m1.ack;
      sb.push_back(x);
   end

   task automatic check(string name, logic [3:0] act, logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (sb.size() == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL sb_empty at %0t: got 0 entries expected 1", $time);
      end else begin
         x = sb.pop_front();
         check("outreset_", outreset_, x.o);
         check("busy", {3'b0, busy}, {3'b0, x.b});
         check("ack", {3'b0, sw_reset_ack}, {3'b0, x.a});
         check("outreset1_", {3'b0, outreset1_}, {3'b0, x.o1});
         check("busy1", {3'b0, busy1}, {3'b0, x.b1});
         check("ack1", {3'b0, sw_reset_ack1}, {3'b0, x.a1});
      end
   end

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic sw_pulse();
      sw_reset_req = 1'b1;
      cyc(1);
      sw_reset_req = 1'b0;
   endtask

   initial begin
      // power-on
      cyc(3);
      rst = 1'b0;
      cyc(40);
      // SW request from idle
      sw_pulse();
      cyc(40);
      // restart while 0011
      sw_pulse();
      cyc(21);
      sw_pulse();
      cyc(40);
      // test mode mid-sequence
      sw_pulse();
      cyc(10);
      test_mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
         direct_reset_ = ~direct_reset_;
         cyc(1);
      end
      test_mode = 1'b0;
      cyc(30);
      // rst colliding with sw request in RELEASE
      sw_pulse();
      cyc(22);
      rst = 1'b1;
      sw_reset_req = 1'b1;
      cyc(1);
      rst = 1'b0;
      sw_reset_req = 1'b0;
      cyc(40);
      // held request
      sw_reset_req = 1'b1;
      cyc(30);
      sw_reset_req = 1'b0;
      cyc(40);
      // random traffic
      for (int i = 0; i < 1500; i++) begin
         rst           = ($urandom_range(0, 99) < 2);
         sw_reset_req  = ($urandom_range(0, 99) < 4);
         if ($urandom_range(0, 49) == 0) test_mode = ~test_mode;
         direct_reset_ = 1'($urandom);
         cyc(1);
      end
      rst = 1'b0;
      sw_reset_req = 1'b0;
      test_mode = 1'b0;
      cyc(40);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
